// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC register bank: register index map,
// default widths and the frame-tracking state encoding.
package rtc_pkg;

  localparam int unsigned RTC_NUM_REGS = 10;
  localparam int unsigned RTC_DATA_W   = 8;

  localparam int unsigned IDX_SEG_HORA   = 0;
  localparam int unsigned IDX_MIN_HORA   = 1;
  localparam int unsigned IDX_HORA_HORA  = 2;
  localparam int unsigned IDX_DIA_FECHA  = 3;
  localparam int unsigned IDX_MES_FECHA  = 4;
  localparam int unsigned IDX_JAHR_FECHA = 5;
  localparam int unsigned IDX_DIA_SEMANA = 6;
  localparam int unsigned IDX_SEG_TIMER  = 7;
  localparam int unsigned IDX_MIN_TIMER  = 8;
  localparam int unsigned IDX_HORA_TIMER = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } rtc_state_e;

endpackage

// File: rtl/rtc_reg_bank_if.sv
// Frame/write bus between the RTC reader (master) and the register bank (slave).
interface rtc_reg_bank_if
  import rtc_pkg::*;
#(
  parameter int unsigned DATA_W   = RTC_DATA_W,
  parameter int unsigned NUM_REGS = RTC_NUM_REGS,
  parameter int unsigned ADDR_W   = 4
);

  logic                         frame_start;
  logic                         wr_en;
  logic [ADDR_W-1:0]            in_addr_mem_local;
  logic [DATA_W-1:0]            in_dato_rtc;
  logic                         frame_end;
  logic [NUM_REGS*DATA_W-1:0]   regs_out;
  logic                         bank_valid;
  logic                         update_pulse;
  logic [NUM_REGS-1:0]          wr_mask;
  logic                         addr_err;
  logic                         bcd_err;

  modport master (
    output frame_start, wr_en, in_addr_mem_local, in_dato_rtc, frame_end,
    input  regs_out, bank_valid, update_pulse, wr_mask, addr_err, bcd_err
  );

  modport slave (
    input  frame_start, wr_en, in_addr_mem_local, in_dato_rtc, frame_end,
    output regs_out, bank_valid, update_pulse, wr_mask, addr_err, bcd_err
  );

endinterface

// File: rtl/rtc_bcd_check.sv
// Flags a data word in which any complete 4-bit nibble exceeds 9.
module rtc_bcd_check
  import rtc_pkg::*;
#(
  parameter int unsigned DATA_W = RTC_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  output logic              invalid_c
);

  localparam int unsigned NIBBLES = DATA_W / 4;

  always_comb begin
    invalid_c = 1'b0;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (data[n*4 +: 4] > 4'd9) invalid_c = 1'b1;
    end
  end

endmodule

// File: rtl/rtc_reg_bank.sv
// Registered RTC register bank: captures a burst of RTC bytes and, in shadow
// mode, publishes the whole frame at once on frame_end.
module rtc_reg_bank
  import rtc_pkg::*;
#(
  parameter int unsigned DATA_W    = RTC_DATA_W,
  parameter int unsigned NUM_REGS  = RTC_NUM_REGS,
  parameter int unsigned ADDR_W    = 4,
  parameter bit          SHADOW    = 1'b1,
  parameter bit          BCD_CHECK = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  rtc_reg_bank_if.slave bus
);

  typedef logic [NUM_REGS-1:0][DATA_W-1:0] bank_t;

  // One extra bit so the bound still compares correctly when 2**ADDR_W == NUM_REGS.
  localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);

  rtc_state_e          state_q, state_d;
  bank_t               staging_q, staging_d;
  bank_t               regs_q, regs_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] commit_mask;
  logic                bank_valid_q, bank_valid_d;
  logic                update_q, update_d;
  logic                addr_err_q, addr_err_d;
  logic                bcd_err_q, bcd_err_d;
  logic                addr_ok;
  logic                commit;
  logic                data_bad_c;

  rtc_bcd_check #(.DATA_W(DATA_W)) u_bcd_check (
    .data      (bus.in_dato_rtc),
    .invalid_c (data_bad_c)
  );

  // Write decode; the commit mask includes a write landing in the frame_end cycle.
  always_comb begin
    wr_hit  = '0;
    addr_ok = ({1'b0, bus.in_addr_mem_local} < NUM_REGS_A);
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = bus.wr_en && addr_ok && (bus.in_addr_mem_local == ADDR_W'(i));
    end
    commit_mask = bus.frame_end ? (mask_q | wr_hit) : '0;
    commit      = |commit_mask;
  end

  // Data path: staging always tracks writes; outputs follow writes or commits.
  always_comb begin
    staging_d = staging_q;
    regs_d    = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_hit[i]) begin
        staging_d[i] = bus.in_dato_rtc;
        if (!SHADOW) regs_d[i] = bus.in_dato_rtc;
      end
    end
    if (SHADOW) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_mask[i]) regs_d[i] = staging_d[i];
      end
    end
  end

  // Frame tracking and flags; a frame_end commit overrides any other transition.
  always_comb begin
    state_d      = state_q;
    update_d     = 1'b0;
    mask_d       = (bus.frame_start ? '0 : mask_q) | wr_hit;
    addr_err_d   = (bus.frame_start ? 1'b0 : addr_err_q) | (bus.wr_en && !addr_ok);
    bcd_err_d    = (bus.frame_start ? 1'b0 : bcd_err_q) | (BCD_CHECK && (|wr_hit) && data_bad_c);
    bank_valid_d = bank_valid_q | commit;

    case (state_q)
      IDLE:    if (bus.frame_start) state_d = CAPTURE;
      CAPTURE: if (bus.frame_end && !bus.frame_start) state_d = IDLE;
      COMMIT:  state_d = bus.frame_start ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase

    if (SHADOW && commit) state_d = COMMIT;

    update_d = (state_d == COMMIT) || (!SHADOW && (|wr_hit));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      staging_q    <= '0;
      regs_q       <= '0;
      mask_q       <= '0;
      bank_valid_q <= 1'b0;
      update_q     <= 1'b0;
      addr_err_q   <= 1'b0;
      bcd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      staging_q    <= staging_d;
      regs_q       <= regs_d;
      mask_q       <= mask_d;
      bank_valid_q <= bank_valid_d;
      update_q     <= update_d;
      addr_err_q   <= addr_err_d;
      bcd_err_q    <= bcd_err_d;
    end
  end

  assign bus.regs_out     = regs_q;
  assign bus.wr_mask      = mask_q;
  assign bus.bank_valid   = bank_valid_q;
  assign bus.update_pulse = update_q;
  assign bus.addr_err     = addr_err_q;
  assign bus.bcd_err      = bcd_err_q;

endmodule

// File: tb/tb_rtc_reg_bank.sv
// Directed bench for rtc_reg_bank: a shadowed instance and a direct-write instance.
module tb_rtc_reg_bank;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  rtc_reg_bank_if #(.DATA_W(8), .NUM_REGS(10), .ADDR_W(4)) bus1 ();
  rtc_reg_bank_if #(.DATA_W(8), .NUM_REGS(10), .ADDR_W(4)) bus0 ();

  rtc_reg_bank #(.DATA_W(8), .NUM_REGS(10), .ADDR_W(4), .SHADOW(1'b1), .BCD_CHECK(1'b1)) u_dut_shadow (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  rtc_reg_bank #(.DATA_W(8), .NUM_REGS(10), .ADDR_W(4), .SHADOW(1'b0), .BCD_CHECK(1'b1)) u_dut_direct (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input logic fs, input logic we, input logic [3:0] a,
                      input logic [7:0] d, input logic fe);
    bus1.frame_start       = fs;
    bus1.wr_en             = we;
    bus1.in_addr_mem_local = a;
    bus1.in_dato_rtc       = d;
    bus1.frame_end         = fe;
  endtask

  task automatic set0(input logic fs, input logic we, input logic [3:0] a,
                      input logic [7:0] d, input logic fe);
    bus0.frame_start       = fs;
    bus0.wr_en             = we;
    bus0.in_addr_mem_local = a;
    bus0.in_dato_rtc       = d;
    bus0.frame_end         = fe;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    set1(0, 0, 4'd0, 8'h00, 0);
    set0(0, 0, 4'd0, 8'h00, 0);
    tick();
    tick();

    // Reset state
    chk("rst_regs",   bus1.regs_out, 80'h0);
    chk("rst_valid",  bus1.bank_valid, 1'b0);
    chk("rst_pulse",  bus1.update_pulse, 1'b0);
    chk("rst_mask",   bus1.wr_mask, 10'h000);

    // Reset mid-frame discards the partial frame immediately
    reset_n = 1'b1;
    set1(1, 0, 4'd0, 8'h00, 0); tick();
    set1(0, 1, 4'd0, 8'h45, 0); tick();
    chk("pre_rst_mask", bus1.wr_mask, 10'h001);
    reset_n = 1'b0;
    #1;
    chk("async_rst_mask", bus1.wr_mask, 10'h000);
    chk("async_rst_regs", bus1.regs_out, 80'h0);
    set1(0, 0, 4'd0, 8'h00, 0);
    tick();
    reset_n = 1'b1;

    // Empty frame_end: no commit, no pulse
    set1(0, 0, 4'd0, 8'h00, 1); tick();
    chk("empty_fe_pulse", bus1.update_pulse, 1'b0);
    chk("empty_fe_regs",  bus1.regs_out, 80'h0);
    chk("empty_fe_valid", bus1.bank_valid, 1'b0);
    set1(0, 0, 4'd0, 8'h00, 0); tick();
    chk("empty_fe_pulse2", bus1.update_pulse, 1'b0);

    // Atomic commit of time
    set1(1, 0, 4'd0, 8'h00, 0); tick();
    set1(0, 1, 4'd0, 8'h59, 0); tick();
    chk("atomic_hold0", bus1.regs_out, 80'h0);
    set1(0, 1, 4'd2, 8'h23, 0); tick();
    set1(0, 1, 4'd1, 8'h17, 0); tick();
    chk("atomic_hold1", bus1.regs_out, 80'h0);
    chk("atomic_mask_pre", bus1.wr_mask, 10'h007);
    chk("atomic_pulse_pre", bus1.update_pulse, 1'b0);
    set1(0, 0, 4'd0, 8'h00, 1); tick();
    chk("atomic_regs",  bus1.regs_out, 80'h231759);
    chk("atomic_pulse", bus1.update_pulse, 1'b1);
    chk("atomic_valid", bus1.bank_valid, 1'b1);
    chk("atomic_mask",  bus1.wr_mask, 10'h007);
    set1(0, 0, 4'd0, 8'h00, 0); tick();
    chk("atomic_pulse_end", bus1.update_pulse, 1'b0);
    chk("atomic_regs_hold", bus1.regs_out, 80'h231759);

    // Partial frame keeps unwritten registers
    set1(1, 0, 4'd0, 8'h00, 0); tick();
    chk("partial_mask_clr", bus1.wr_mask, 10'h000);
    set1(0, 1, 4'd3, 8'h31, 0); tick();
    set1(0, 0, 4'd0, 8'h00, 1); tick();
    chk("partial_regs",  bus1.regs_out, 80'h31231759);
    chk("partial_mask",  bus1.wr_mask, 10'h008);
    chk("partial_pulse", bus1.update_pulse, 1'b1);
    set1(0, 0, 4'd0, 8'h00, 0); tick();

    // Error flags
    set1(1, 0, 4'd0, 8'h00, 0); tick();
    set1(0, 1, 4'd12, 8'h7A, 0); tick();
    chk("addr_err_set",   bus1.addr_err, 1'b1);
    chk("addr_err_nobcd", bus1.bcd_err, 1'b0);
    chk("addr_err_mask",  bus1.wr_mask, 10'h000);
    set1(0, 1, 4'd4, 8'h5F, 0); tick();
    chk("bcd_err_set", bus1.bcd_err, 1'b1);
    set1(0, 0, 4'd0, 8'h00, 1); tick();
    chk("bcd_commit_regs", bus1.regs_out, 80'h5F31231759);
    chk("bcd_commit_mask", bus1.wr_mask, 10'h010);
    chk("errs_sticky", {bus1.addr_err, bus1.bcd_err}, 2'b11);
    set1(0, 0, 4'd0, 8'h00, 0); tick();
    set1(1, 0, 4'd0, 8'h00, 0); tick();
    chk("errs_clear", {bus1.addr_err, bus1.bcd_err}, 2'b00);

    // Write in the frame_end cycle joins the commit
    set1(0, 1, 4'd9, 8'h08, 1); tick();
    chk("fe_write_regs",  bus1.regs_out, 80'h08000000005F31231759);
    chk("fe_write_mask",  bus1.wr_mask, 10'h200);
    chk("fe_write_pulse", bus1.update_pulse, 1'b1);
    set1(0, 0, 4'd0, 8'h00, 0); tick();

    // Simultaneous frame_start/frame_end: commit with old mask, then clear
    set1(0, 1, 4'd6, 8'h04, 0); tick();
    chk("sim_mask_pre", bus1.wr_mask, 10'h240);
    set1(1, 0, 4'd0, 8'h00, 1); tick();
    chk("sim_regs",  bus1.regs_out, 80'h08000004005F31231759);
    chk("sim_mask",  bus1.wr_mask, 10'h000);
    chk("sim_pulse", bus1.update_pulse, 1'b1);

    // Last write wins within a frame
    set1(0, 1, 4'd5, 8'h11, 0); tick();
    chk("lww_pulse_end", bus1.update_pulse, 1'b0);
    set1(0, 1, 4'd5, 8'h12, 0); tick();
    set1(0, 0, 4'd0, 8'h00, 1); tick();
    chk("lww_regs", bus1.regs_out, 80'h08000004125F31231759);
    chk("lww_mask", bus1.wr_mask, 10'h020);

    // Back-to-back frame: frame_start right after frame_end
    set1(1, 0, 4'd0, 8'h00, 0); tick();
    chk("b2b_pulse", bus1.update_pulse, 1'b0);
    chk("b2b_mask",  bus1.wr_mask, 10'h000);
    set1(0, 0, 4'd0, 8'h00, 0); tick();

    // Direct-write instance
    set0(0, 1, 4'd7, 8'h12, 0); tick();
    chk("direct_regs",  bus0.regs_out, 80'h00001200000000000000);
    chk("direct_pulse", bus0.update_pulse, 1'b1);
    chk("direct_mask",  bus0.wr_mask, 10'h080);
    chk("direct_valid_pre", bus0.bank_valid, 1'b0);
    set0(0, 0, 4'd0, 8'h00, 1); tick();
    chk("direct_valid", bus0.bank_valid, 1'b1);
    chk("direct_no_pulse", bus0.update_pulse, 1'b0);
    set0(0, 0, 4'd0, 8'h00, 0); tick();
    chk("direct_no_pulse2", bus0.update_pulse, 1'b0);

    // Async reset with a populated bank
    reset_n = 1'b0;
    #1;
    chk("final_rst_regs",  bus1.regs_out, 80'h0);
    chk("final_rst_valid", bus1.bank_valid, 1'b0);
    chk("final_rst_direct", bus0.regs_out, 80'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
